// File: rtl/game_pkg.sv
// Shared definitions for the game controller.
// Contents: FSM state encoding, default tuning values and a
// saturating 3-digit BCD increment helper used by the score counter.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam int unsigned FLOOR_Y_DEF      = 32'd440;
  localparam int unsigned DEATH_FRAMES_DEF = 32'd60;
  localparam int unsigned LOCK_FRAMES_DEF  = 32'd30;

  // Add one to a 3-digit BCD value with decimal carry; 999 stays at 999.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and saturating increment.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset (clears the count)
//   clear_i - synchronous clear to 000 (wins over inc_i)
//   inc_i   - add one with decimal carry, holding at 999
//   q_o     - registered count, 3 BCD digits
module bcd_counter3
  import game_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [11:0] q_o
);

  logic [11:0] q_q;
  logic [11:0] q_d;

  // Next count: clear has priority over increment.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = 12'h000;
    end else if (inc_i) begin
      q_d = bcd_inc_sat(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 12'h000;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/game_controller.sv
// Top-level game flow controller: IDLE -> PLAYING -> DYING -> GAME_OVER.
// Inputs:  clk, reset_n (async, active-low), flap_btn (raw async button),
//          frame_tick (one-clk per frame), pipe_collision, pipe_pass,
//          bird_y (10-bit bird top coordinate).
// Outputs: pipe_enable, pipe_reset, bird_reset, flap, game_state,
//          score_bcd / high_bcd (3 BCD digits each). All outputs registered.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned FLOOR_Y      = FLOOR_Y_DEF,
  parameter int unsigned DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int unsigned LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flap_btn,
  input  logic        frame_tick,
  input  logic        pipe_collision,
  input  logic        pipe_pass,
  input  logic [9:0]  bird_y,
  output logic        pipe_enable,
  output logic        pipe_reset,
  output logic        bird_reset,
  output logic        flap,
  output logic [1:0]  game_state,
  output logic [11:0] score_bcd,
  output logic [11:0] high_bcd
);

  localparam logic [9:0] FLOOR_C      = 10'(FLOOR_Y);
  localparam logic [7:0] DEATH_LAST_C = 8'(DEATH_FRAMES - 32'd1);
  localparam logic [7:0] LOCK_C       = 8'(LOCK_FRAMES);

  logic        sync1_q, sync2_q, sync3_q;
  logic        flap_edge_q;
  logic        pass_prev_q;
  state_e      state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic        pipe_enable_q, pipe_enable_d;
  logic        flap_q, flap_d;
  logic        clr_pulse_q, clr_pulse_d;
  logic [11:0] high_q, high_d;
  logic [11:0] score_s;
  logic        pass_edge_s;
  logic        score_clear_s;
  logic        score_inc_s;

  assign pass_edge_s = pipe_pass & ~pass_prev_q;

  // Button synchroniser plus edge flop; flap_edge_q is high the 3rd clk after the press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      flap_edge_q <= 1'b0;
      pass_prev_q <= 1'b0;
    end else begin
      sync1_q     <= flap_btn;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      flap_edge_q <= sync2_q & ~sync3_q;
      pass_prev_q <= pipe_pass;
    end
  end

  // Next-state, frame counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flap_edge_q) state_d = ST_PLAYING;
        else             state_d = ST_IDLE;
      end
      ST_PLAYING: begin
        if (pipe_collision || (bird_y >= FLOOR_C)) state_d = ST_DYING;
        else                                       state_d = ST_PLAYING;
      end
      ST_DYING: begin
        // The DEATH_FRAMES-th tick itself triggers the move.
        if (frame_tick && (frame_q == DEATH_LAST_C)) state_d = ST_GAME_OVER;
        else                                         state_d = ST_DYING;
      end
      ST_GAME_OVER: begin
        if (flap_edge_q && (frame_q >= LOCK_C)) state_d = ST_IDLE;
        else                                    state_d = ST_GAME_OVER;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter restarts on any state change; the tick of that clk is dropped.
    // Saturation keeps a long GAME_OVER from wrapping back into the lock window.
    if (state_d != state_q) begin
      frame_d = 8'd0;
    end else if (frame_tick && (frame_q != 8'hFF)) begin
      frame_d = frame_q + 8'd1;
    end else begin
      frame_d = frame_q;
    end

    pipe_enable_d = (state_d == ST_PLAYING);
    flap_d        = flap_edge_q && ((state_q == ST_IDLE) || (state_q == ST_PLAYING));
    clr_pulse_d   = (state_q == ST_GAME_OVER) && (state_d == ST_IDLE);

    if ((state_q == ST_DYING) && (state_d == ST_GAME_OVER) && (score_s > high_q)) begin
      high_d = score_s;
    end else begin
      high_d = high_q;
    end
  end

  assign score_clear_s = (state_q == ST_IDLE) && (state_d == ST_PLAYING);
  assign score_inc_s   = (state_q == ST_PLAYING) && pass_edge_s;

  // State and output registers; the clear pulses sit high throughout reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      frame_q       <= 8'd0;
      pipe_enable_q <= 1'b0;
      flap_q        <= 1'b0;
      clr_pulse_q   <= 1'b1;
      high_q        <= 12'h000;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      pipe_enable_q <= pipe_enable_d;
      flap_q        <= flap_d;
      clr_pulse_q   <= clr_pulse_d;
      high_q        <= high_d;
    end
  end

  bcd_counter3 u_score (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (score_clear_s),
    .inc_i   (score_inc_s),
    .q_o     (score_s)
  );

  assign game_state  = state_q;
  assign pipe_enable = pipe_enable_q;
  assign flap        = flap_q;
  assign pipe_reset  = clr_pulse_q;
  assign bird_reset  = clr_pulse_q;
  assign score_bcd   = score_s;
  assign high_bcd    = high_q;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  localparam int FLOOR = 440;
  localparam int DEATH = 60;
  localparam int LOCK  = 30;

  logic        clk = 1'b0;
  logic        reset_n, flap_btn, frame_tick, pipe_collision, pipe_pass;
  logic [9:0]  bird_y;
  logic        pipe_enable, pipe_reset, bird_reset, flap;
  logic [1:0]  game_state;
  logic [11:0] score_bcd, high_bcd;

  always #5 clk = ~clk;

  game_controller dut (
    .clk(clk), .reset_n(reset_n), .flap_btn(flap_btn), .frame_tick(frame_tick),
    .pipe_collision(pipe_collision), .pipe_pass(pipe_pass), .bird_y(bird_y),
    .pipe_enable(pipe_enable), .pipe_reset(pipe_reset), .bird_reset(bird_reset),
    .flap(flap), .game_state(game_state), .score_bcd(score_bcd), .high_bcd(high_bcd)
  );

  typedef struct {
    logic [1:0]  st;
    logic [11:0] score;
    logic [11:0] high;
  } rec_t;

  rec_t        exp_q[$];
  logic [11:0] score_q[$];
  int          flap_pending = 0;
  int          rst_pending  = 0;
  int          checks       = 0;
  int          failures     = 0;
  bit          mon_en       = 1'b0;
  int          exp_score    = 0;
  int          exp_high     = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a state change, score change or pulse.
  logic [1:0]  last_gs;
  logic [11:0] last_score;
  logic [1:0]  mon_state;
  logic [11:0] mon_high;
  logic        prev_pulse;

  always @(negedge clk) begin
    rec_t        r;
    logic [11:0] es;
    if (!mon_en) begin
      last_gs    = 2'd0;
      last_score = 12'h000;
      mon_state  = 2'd0;
      mon_high   = 12'h000;
      prev_pulse = 1'b0;
    end else begin
      if (game_state !== last_gs) begin
        if (exp_q.size() == 0) begin
          chk("state_unexpected", 32'(game_state), 32'(last_gs));
        end else begin
          r = exp_q.pop_front();
          chk("state", 32'(game_state), 32'(r.st));
          chk("score_at_state", 32'(score_bcd), 32'(r.score));
          chk("high_at_state", 32'(high_bcd), 32'(r.high));
          mon_state = r.st;
          mon_high  = r.high;
        end
        last_gs = game_state;
      end
      chk("pipe_enable", 32'(pipe_enable), 32'(mon_state == 2'd1));
      chk("high_hold", 32'(high_bcd), 32'(mon_high));
      if (score_bcd !== last_score) begin
        if (score_q.size() == 0) begin
          chk("score_unexpected", 32'(score_bcd), 32'(last_score));
        end else begin
          es = score_q.pop_front();
          chk("score", 32'(score_bcd), 32'(es));
        end
        last_score = score_bcd;
      end
      if (flap === 1'b1) begin
        chk("flap_expected", 32'(flap_pending > 0), 32'd1);
        if (flap_pending > 0) flap_pending--;
      end
      if (pipe_reset || bird_reset) begin
        chk("reset_pair", 32'({pipe_reset, bird_reset}), 32'd3);
        chk("reset_one_clk", 32'(prev_pulse), 32'd0);
        chk("reset_expected", 32'(rst_pending > 0), 32'd1);
        if (rst_pending > 0) rst_pending--;
      end
      prev_pulse = pipe_reset | bird_reset;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Press the button; lat = first clk (after the press) where PLAYING is seen.
  task automatic press_flap(output int lat);
    int hold;
    hold = int'($urandom_range(1, 3));
    lat  = 0;
    flap_btn = 1'b1;
    for (int i = 1; i <= hold + 5; i++) begin
      cyc();
      if (i == hold) flap_btn = 1'b0;
      if (lat == 0 && game_state == 2'd1) lat = i;
    end
  endtask

  task automatic do_pass(input bit counted);
    pipe_pass = 1'b1;
    if (counted && exp_score < 999) begin
      exp_score++;
      score_q.push_back(to_bcd(exp_score));
    end
    idle(int'($urandom_range(1, 3)));
    pipe_pass = 1'b0;
    idle(int'($urandom_range(1, 2)));
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() + score_q.size() + flap_pending + rst_pending) != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_outstanding", 32'(exp_q.size() + score_q.size() + flap_pending + rst_pending), 32'd0);
    exp_q.delete();
    score_q.delete();
    flap_pending = 0;
    rst_pending  = 0;
  endtask

  task automatic start_game();
    int lat;
    do_pass(1'b0);
    if (exp_score != 0) score_q.push_back(12'h000);
    exp_score = 0;
    exp_q.push_back('{2'd1, 12'h000, to_bcd(exp_high)});
    flap_pending++;
    press_flap(lat);
    chk("start_latency", 32'(lat >= 1 && lat <= 4), 32'd1);
  endtask

  task automatic play(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      do_pass(1'b1);
      if ($urandom_range(0, 7) == 0) begin
        flap_pending++;
        press_flap(lat);
      end
    end
  endtask

  // kind 0: collision, 1: bird reaches floor, 2: pass edge together with collision.
  task automatic end_play(input int kind, input bit tick);
    case (kind)
      0: pipe_collision = 1'b1;
      1: begin
        bird_y = 10'(FLOOR - 1);
        idle(3);
        bird_y = 10'(FLOOR + int'($urandom_range(0, 40)));
      end
      default: begin
        pipe_collision = 1'b1;
        pipe_pass      = 1'b1;
        if (exp_score < 999) begin
          exp_score++;
          score_q.push_back(to_bcd(exp_score));
        end
      end
    endcase
    exp_q.push_back('{2'd2, to_bcd(exp_score), to_bcd(exp_high)});
    frame_tick = tick;
    cyc();
    pipe_collision = 1'b0;
    pipe_pass      = 1'b0;
    frame_tick     = 1'b0;
    bird_y         = 10'($urandom_range(50, 400));
    idle(2);
  endtask

  task automatic dying();
    int lat;
    send_ticks(25);
    press_flap(lat);
    do_pass(1'b0);
    send_ticks(DEATH - 26);
    if (exp_score > exp_high) exp_high = exp_score;
    exp_q.push_back('{2'd3, to_bcd(exp_score), to_bcd(exp_high)});
    send_ticks(1);
  endtask

  task automatic gameover();
    int lat;
    send_ticks(10);
    press_flap(lat);
    idle(3);
    send_ticks(LOCK - 10 + int'($urandom_range(0, 4)));
    exp_q.push_back('{2'd0, to_bcd(exp_score), to_bcd(exp_high)});
    rst_pending++;
    press_flap(lat);
    wait_drain();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; flap_btn = 1'b0; frame_tick = 1'b0;
    pipe_collision = 1'b0; pipe_pass = 1'b0; bird_y = 10'd200;
    idle(3);
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_score", 32'(score_bcd), 32'h000);
    chk("rst_high", 32'(high_bcd), 32'h000);
    chk("rst_pipe_enable", 32'(pipe_enable), 32'd0);
    chk("rst_flap", 32'(flap), 32'd0);
    chk("rst_pipe_reset", 32'(pipe_reset), 32'd1);
    chk("rst_bird_reset", 32'(bird_reset), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("rel_pipe_reset", 32'(pipe_reset), 32'd0);
    chk("rel_bird_reset", 32'(bird_reset), 32'd0);
    mon_en = 1'b1;

    // Game 1: exactly 12 passes, collision with a simultaneous frame_tick.
    start_game();
    play(12);
    wait_drain();
    chk("score_12", 32'(score_bcd), 32'h012);
    end_play(0, 1'b1);
    dying();
    gameover();

    // Game 2: smaller score, floor hit.
    start_game();
    play(int'($urandom_range(3, 10)));
    end_play(1, 1'b0);
    dying();
    gameover();

    // Game 3: pass and collision in the same clk.
    start_game();
    play(int'($urandom_range(10, 20)));
    end_play(2, 1'b0);
    dying();
    gameover();

    // Game 4: run the score into saturation.
    start_game();
    play(1002);
    wait_drain();
    chk("score_sat", 32'(score_bcd), 32'h999);
    end_play(2, 1'b0);
    dying();
    gameover();
    chk("high_sat", 32'(high_bcd), 32'h999);

    // Game 5: reset dropped in the middle of DYING.
    start_game();
    play(4);
    end_play(1, 1'b0);
    send_ticks(20);
    wait_drain();
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(game_state), 32'd0);
    chk("abort_pipe_enable", 32'(pipe_enable), 32'd0);
    chk("abort_flap", 32'(flap), 32'd0);
    chk("abort_score", 32'(score_bcd), 32'h000);
    chk("abort_high", 32'(high_bcd), 32'h000);
    chk("abort_pipe_reset", 32'(pipe_reset), 32'd1);
    chk("abort_bird_reset", 32'(bird_reset), 32'd1);
    exp_score = 0;
    exp_high  = 0;
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("rel2_pipe_reset", 32'(pipe_reset), 32'd0);
    chk("rel2_bird_reset", 32'(bird_reset), 32'd0);
    mon_en = 1'b1;

    // Game 6: best score restarts from zero after the reset.
    start_game();
    play(5);
    end_play(0, 1'b0);
    dying();
    gameover();
    chk("high_after_reset", 32'(high_bcd), 32'(to_bcd(exp_high)));

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter FLOOR_Y, default 440, meaning: bird_y value at or above which the bird is grounded.
REQ-002 Parameter DEATH_FRAMES, default 60, meaning: frame_tick count spent in DYING.
REQ-003 Parameter LOCK_FRAMES, default 30, meaning: frame_tick count in GAME_OVER before flap is accepted.
REQ-004 Port clk, input, 1, meaning: system clock; the block SHALL use one clock only.
REQ-005 Port reset_n, input, 1, meaning: asynchronous, active-low reset.
REQ-006 Port flap_btn, input, 1, meaning: raw, asynchronous player button, active-high.
REQ-007 Port frame_tick, input, 1, meaning: one-clk pulse per video frame.
REQ-008 Port pipe_collision, input, 1, meaning: level collision flag from the pipe renderer.
REQ-009 Port pipe_pass, input, 1, meaning: score pulse or level from the pipe renderer.
REQ-010 Port bird_y, input, 10, meaning: bird top y coordinate.
REQ-011 Port pipe_enable, output, 1, meaning: pipe scroll enable.
REQ-012 Port pipe_reset, output, 1, meaning: one-clk active-high clear for the pipes.
REQ-013 Port bird_reset, output, 1, meaning: one-clk active-high bird re-centre.
REQ-014 Port flap, output, 1, meaning: one-clk flap pulse to bird physics.
REQ-015 Port game_state, output, 2, meaning: IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3.
REQ-016 Port score_bcd, output, 12, meaning: current score as 3 BCD digits.
REQ-017 Port high_bcd, output, 12, meaning: best score as 3 BCD digits.

Function
REQ-018 flap_btn SHALL pass through a 2-flop synchroniser, then a rising-edge detector; flap_edge is one clk long and appears 3 clk after the input edge.
REQ-019 IDLE: on flap_edge, go to PLAYING, pulse flap, and clear score_bcd to 0.
REQ-020 PLAYING: pipe_enable=1, and flap mirrors flap_edge.
REQ-021 PLAYING: if pipe_collision=1 or bird_y>=FLOOR_Y, go to DYING on the next clk; pipe_enable drops in that same clk.
REQ-022 PLAYING: a rising edge of pipe_pass (registered previous value 0, current 1) SHALL increment score_bcd by 1 with decimal carry (009->010, 099->100).
REQ-023 score_bcd SHALL saturate at 999.
REQ-024 pipe_pass edges outside PLAYING SHALL be ignored.
REQ-025 If a pass edge and a collision occur in the same clk, the increment SHALL be applied before entering DYING.
REQ-026 DYING: pipe_enable=0 and flap inputs are ignored; frame_tick pulses are counted, and after DEATH_FRAMES ticks the FSM goes to GAME_OVER.
REQ-027 On entry to GAME_OVER, high_bcd SHALL load score_bcd if score_bcd is greater than high_bcd (plain compare of the 12-bit BCD value); the equal case leaves high_bcd unchanged.
REQ-028 GAME_OVER: flap_edge SHALL be ignored until LOCK_FRAMES frame_ticks have elapsed.
REQ-029 GAME_OVER: after the lock, flap_edge SHALL go to IDLE and pulse pipe_reset and bird_reset together for exactly one clk.
REQ-030 The frame counter SHALL be 8 bits wide and clear on every state change.
REQ-031 frame_tick arriving in the same clk as a state change SHALL NOT be counted.
REQ-032 All outputs SHALL be registered.
REQ-033 pipe_enable SHALL be 1 only in PLAYING.

Reset
REQ-034 While reset_n=0, outputs SHALL be: game_state=IDLE, pipe_enable=0, flap=0, score_bcd=0, high_bcd=0, frame counter=0, and synchroniser flops=0.
REQ-035 While reset_n=0, pipe_reset=1 and bird_reset=1; both SHALL deassert on the first clk after release.
REQ-036 Reset asserted mid-game SHALL abort any state immediately and lose high_bcd.
REQ-037 Release SHALL be synchronised by the system-level reset bridge; no internal release synchroniser is required.

Structure
REQ-038 Package game_pkg SHALL hold the state encoding and the default FLOOR_Y, DEATH_FRAMES, and LOCK_FRAMES values.
REQ-039 Sub-module bcd_counter3 SHALL provide clear, inc, saturate-at-999 behaviour and a 12-bit q output, instantiated once for the score.

Verification
REQ-040 Hold reset_n=0, then release -> game_state=0, score_bcd=0x000, and pipe_reset=1 during reset, then 0 from the first clk after release.
REQ-041 Flap pulse in IDLE -> game_state=1 and pipe_enable=1 within 4 clk; 12 pipe_pass pulses -> score_bcd=0x012.
REQ-042 Preload score to 998, then apply 3 pass pulses -> score_bcd=0x999 (saturated).
REQ-043 Set bird_y=440 in PLAYING -> DYING next clk; after 60 frame_ticks -> GAME_OVER, with high_bcd updated to the score.
REQ-044 Flap at GAME_OVER tick 10 -> ignored; flap after tick 30 -> IDLE with a single one-clk pipe_reset and bird_reset.
REQ-045 Pass and collision in the same clk -> score +1 and the FSM enters DYING; drop reset_n mid-DYING -> all outputs take their reset values immediately.
